riscv_core_divider: RTL and testbench
=====================================

RISCV_CORE_DIVIDER -- requirements
Module: riscv_core_divider

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; XLEN SHALL be even.
REQ-002 SHALL have port i_divider_clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port i_divider_rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port i_divider_start, input, 1, request to start a division.
REQ-005 SHALL have port i_divider_flush, input, 1, abort any operation in progress.
REQ-006 SHALL have port i_divider_dividend, input, XLEN, dividend magnitude from the division input stage.
REQ-007 SHALL have port i_divider_divisor, input, XLEN, divisor magnitude from the division input stage.
REQ-008 SHALL have port i_divider_control, input, 2, op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU; in word mode 00 DIVW, 01 DIVUW, 10 REMW, 11 REMUW.
REQ-009 SHALL have port i_divider_isword, input, 1, 1 = 32-bit word op.
REQ-010 SHALL have port i_divider_dividend_neg, input, 1, sign of the original dividend at the operating width.
REQ-011 SHALL have port i_divider_divisor_neg, input, 1, sign of the original divisor at the operating width.
REQ-012 SHALL have port o_divider_ready, output, 1, high only in IDLE.
REQ-013 SHALL have port o_divider_busy, output, 1, high in CALC or DONE.
REQ-014 SHALL have port o_divider_done, output, 1, one-cycle result-valid pulse.
REQ-015 SHALL have port o_divider_result, output, XLEN, final rd value.

Function
REQ-016 Operating width W SHALL be XLEN when isword=0 and XLEN/2 when isword=1; in word mode only bits [W-1:0] of dividend/divisor SHALL be used.
REQ-017 Signed op (control[0]=0) SHALL apply the neg inputs; unsigned op SHALL treat both as 0.
REQ-018 FSM SHALL have states IDLE, CALC, DONE.
  - IDLE -> CALC on start when divisor[W-1:0] != 0.
  - IDLE -> DONE on start when divisor[W-1:0] == 0.
  - CALC -> DONE after exactly W iterations.
  - DONE -> IDLE unconditionally after one cycle.
REQ-019 Start SHALL be sampled only in IDLE; start in CALC/DONE SHALL be ignored. Operands, control, isword and signs SHALL be registered at the accepting edge; later input changes SHALL have no effect.
REQ-020 CALC SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left 1; if rem >= divisor then subtract and set the quotient LSB to 1.
REQ-021 An iteration counter SHALL stop CALC after W steps (64 for XLEN, 32 for word).
REQ-022 Latency, start high in cycle 0: done high in cycle W+1 (65 for 64-bit, 33 for word); on divide-by-zero, done high in cycle 1.
REQ-023 Quotient sign SHALL be dividend_neg XOR divisor_neg; remainder sign SHALL be dividend_neg; negative values SHALL be two's-complement negated at width W.
REQ-024 DIV-type ops SHALL return the quotient; REM-type ops SHALL return the remainder.
REQ-025 Divide-by-zero: quotient SHALL be all ones at W; remainder SHALL be the original dividend (magnitude re-negated if dividend_neg).
REQ-026 Signed overflow (dividend = -2^(W-1), divisor = -1): quotient SHALL be -2^(W-1) and remainder 0.
REQ-027 In word mode, the 32-bit result SHALL be sign-extended to XLEN, including DIVUW and REMUW.
REQ-028 o_divider_result SHALL be registered on entry to DONE and held until the next accepted start.
REQ-029 Flush in CALC or DONE SHALL force IDLE at the next edge with no done pulse; flush in IDLE SHALL have no effect, and a start in the same cycle SHALL be ignored.

Reset
REQ-030 Synchronous reset SHALL set state IDLE, counter 0 and all internal registers 0, with o_divider_ready=1, busy=0, done=0, result=0.
REQ-031 Reset SHALL take priority over start and flush; reset mid-CALC SHALL abort with no done pulse.

Verification
REQ-032 DIV, dividend mag 7 neg=1, divisor mag 2 neg=0 -> done at cycle 65, result 0xFFFF_FFFF_FFFF_FFFD (-3).
REQ-033 REM with the same operands -> result 0xFFFF_FFFF_FFFF_FFFF (-1); REMU 7/2 -> 1.
REQ-034 DIVU, divisor 0, dividend 5 -> done at cycle 1, result all ones; REMU -> 5.
REQ-035 DIVW, dividend 0x8000_0000 neg=1, divisor 1 neg=1 -> done at cycle 33, result 0xFFFF_FFFF_8000_0000; REMW -> 0.
REQ-036 DIVUW 0xFFFF_FFFE / 1 -> result 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
REQ-037 Start, then flush at cycle 10 -> no done pulse and ready at cycle 11; a start at cycle 5 is ignored; reset at cycle 20 of a new op -> ready=1 and result=0 in cycle 21.

Source files
------------

// File: rtl/riscv_core_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M/RV32M-style DIV/REM ops.
// Operands arrive as magnitudes plus sign flags; the final sign fix-up and word sign-extension happen on entry to DONE.
module riscv_core_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_divider_clk,
    input  logic            i_divider_rst,
    input  logic            i_divider_start,
    input  logic            i_divider_flush,
    input  logic [XLEN-1:0] i_divider_dividend,
    input  logic [XLEN-1:0] i_divider_divisor,
    input  logic [1:0]      i_divider_control,
    input  logic            i_divider_isword,
    input  logic            i_divider_dividend_neg,
    input  logic            i_divider_divisor_neg,
    output logic            o_divider_ready,
    output logic            o_divider_busy,
    output logic            o_divider_done,
    output logic [XLEN-1:0] o_divider_result
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] divisor_r;
    logic [1:0]      control_r;
    logic            isword_r;
    logic            dividend_neg_r;
    logic            divisor_neg_r;
    logic [XLEN-1:0] result_r;

    logic [XLEN-1:0] in_dividend_s;
    logic [XLEN-1:0] in_divisor_s;
    logic            div_zero_s;
    logic            accept_s;
    logic            msb_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN-1:0] rem_next_s;
    logic [XLEN-1:0] quo_next_s;
    logic            last_step_s;

    function automatic logic [XLEN-1:0] width_mask(input logic isword);
        return isword ? {{HALF{1'b0}}, {HALF{1'b1}}} : {XLEN{1'b1}};
    endfunction

    // Sign fix-up, op select and word sign-extension; div-by-zero quotient is never negated.
    function automatic logic [XLEN-1:0] finalize(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic [1:0]      ctrl,
        input logic            isword,
        input logic            dn,
        input logic            dvn,
        input logic            zero
    );
        logic            signed_op;
        logic            q_neg;
        logic            r_neg;
        logic [XLEN-1:0] val;
        signed_op = ~ctrl[0];
        q_neg     = signed_op & (dn ^ dvn) & ~zero;
        r_neg     = signed_op & dn;
        if (ctrl[1]) begin
            val = r_neg ? (~r + {{(XLEN-1){1'b0}}, 1'b1}) : r;
        end else begin
            val = q_neg ? (~q + {{(XLEN-1){1'b0}}, 1'b1}) : q;
        end
        if (isword) begin
            val = {{HALF{val[HALF-1]}}, val[HALF-1:0]};
        end
        return val;
    endfunction

    // Operand masking, start qualification and one restoring step.
    always_comb begin
        in_dividend_s = i_divider_dividend & width_mask(i_divider_isword);
        in_divisor_s  = i_divider_divisor & width_mask(i_divider_isword);
        div_zero_s    = (in_divisor_s == {XLEN{1'b0}});
        accept_s      = (state_r == S_IDLE) & i_divider_start & ~i_divider_flush;
        msb_s         = isword_r ? quo_r[HALF-1] : quo_r[XLEN-1];
        shifted_s     = {rem_r, msb_s};
        if (shifted_s >= {1'b0, divisor_r}) begin
            rem_next_s = shifted_s[XLEN-1:0] - divisor_r;
            quo_next_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[XLEN-1:0];
            quo_next_s = {quo_r[XLEN-2:0], 1'b0};
        end
        last_step_s = (count_r == (isword_r ? CW'(HALF - 1) : CW'(XLEN - 1)));
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = div_zero_s ? S_DONE : S_CALC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (i_divider_flush) begin
                    state_next_s = S_IDLE;
                end else if (last_step_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_CALC;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, operand capture, iteration datapath and result register.
    always_ff @(posedge i_divider_clk) begin
        if (i_divider_rst) begin
            state_r        <= S_IDLE;
            count_r        <= {CW{1'b0}};
            rem_r          <= {XLEN{1'b0}};
            quo_r          <= {XLEN{1'b0}};
            divisor_r      <= {XLEN{1'b0}};
            control_r      <= 2'b00;
            isword_r       <= 1'b0;
            dividend_neg_r <= 1'b0;
            divisor_neg_r  <= 1'b0;
            result_r       <= {XLEN{1'b0}};
        end else begin
            state_r <= state_next_s;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        count_r        <= {CW{1'b0}};
                        rem_r          <= {XLEN{1'b0}};
                        quo_r          <= in_dividend_s;
                        divisor_r      <= in_divisor_s;
                        control_r      <= i_divider_control;
                        isword_r       <= i_divider_isword;
                        dividend_neg_r <= i_divider_dividend_neg;
                        divisor_neg_r  <= i_divider_divisor_neg;
                        if (div_zero_s) begin
                            result_r <= finalize({XLEN{1'b1}}, in_dividend_s, i_divider_control,
                                                 i_divider_isword, i_divider_dividend_neg,
                                                 i_divider_divisor_neg, 1'b1);
                        end
                    end
                end
                S_CALC: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_step_s && !i_divider_flush) begin
                        result_r <= finalize(quo_next_s, rem_next_s, control_r, isword_r,
                                             dividend_neg_r, divisor_neg_r, 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_divider_ready  = (state_r == S_IDLE);
    assign o_divider_busy   = (state_r == S_CALC) | (state_r == S_DONE);
    assign o_divider_done   = (state_r == S_DONE);
    assign o_divider_result = result_r;

endmodule

// File: tb/tb_riscv_core_divider.sv
// Directed table-driven bench for riscv_core_divider plus flush/reset/ignored-start sequences.
module tb_riscv_core_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [1:0]  control;
    logic        isword;
    logic        dividend_neg;
    logic        divisor_neg;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    riscv_core_divider #(.XLEN(64)) dut (
        .i_divider_clk          (clk),
        .i_divider_rst          (rst),
        .i_divider_start        (start),
        .i_divider_flush        (flush),
        .i_divider_dividend     (dividend),
        .i_divider_divisor      (divisor),
        .i_divider_control      (control),
        .i_divider_isword       (isword),
        .i_divider_dividend_neg (dividend_neg),
        .i_divider_divisor_neg  (divisor_neg),
        .o_divider_ready        (ready),
        .o_divider_busy         (busy),
        .o_divider_done         (done),
        .o_divider_result       (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic        isw;
        logic [63:0] dvd;
        logic [63:0] dvs;
        logic        dn;
        logic        dvn;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [1:0] ctrl, input logic isw, input logic [63:0] dvd,
                                input logic [63:0] dvs, input logic dn, input logic dvn,
                                input logic [63:0] exp, input int lat);
        vec_t v;
        v.ctrl = ctrl; v.isw = isw; v.dvd = dvd; v.dvs = dvs;
        v.dn = dn; v.dvn = dvn; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc;
        done_cyc = -1;
        control = v.ctrl; isword = v.isw; dividend = v.dvd; divisor = v.dvs;
        dividend_neg = v.dn; divisor_neg = v.dvn; start = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                dividend = ~v.dvd; divisor = 64'd3; control = ~v.ctrl;
                isword = ~v.isw; dividend_neg = ~v.dn; divisor_neg = ~v.dvn;
                check($sformatf("v%0d_busy_c1", idx), {63'd0, busy}, 64'd1);
            end
            if (done && done_cyc < 0) begin
                done_cyc = n;
                check($sformatf("v%0d_result", idx), result, v.exp);
            end else if (done_cyc > 0 && n == done_cyc + 1) begin
                check($sformatf("v%0d_done_one_cycle", idx), {63'd0, done}, 64'd0);
                check($sformatf("v%0d_ready_after", idx), {63'd0, ready}, 64'd1);
                check($sformatf("v%0d_result_held", idx), result, v.exp);
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), 64'(done_cyc), 64'(v.lat));
    endtask

    initial begin
        logic [63:0] held;
        int saw_done;
        rst = 1'b1; start = 1'b0; flush = 1'b0; dividend = 64'd0; divisor = 64'd0;
        control = 2'b00; isword = 1'b0; dividend_neg = 1'b0; divisor_neg = 1'b0;

        vq.push_back(mk(2'b00, 1'b0, 64'd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65));
        vq.push_back(mk(2'b10, 1'b0, 64'd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65));
        vq.push_back(mk(2'b11, 1'b0, 64'd7, 64'd2, 1'b1, 1'b0, 64'd1, 65));
        vq.push_back(mk(2'b01, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1));
        vq.push_back(mk(2'b11, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, 64'd5, 1));
        vq.push_back(mk(2'b00, 1'b1, 64'h8000_0000, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33));
        vq.push_back(mk(2'b10, 1'b1, 64'h8000_0000, 64'd1, 1'b1, 1'b1, 64'd0, 33));
        vq.push_back(mk(2'b01, 1'b1, 64'hFFFF_FFFE, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 33));
        vq.push_back(mk(2'b01, 1'b0, 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 65));
        vq.push_back(mk(2'b11, 1'b0, 64'd100, 64'd7, 1'b0, 1'b0, 64'd2, 65));
        vq.push_back(mk(2'b01, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 1'b0, 1'b0, 64'd14, 33));
        vq.push_back(mk(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 65));
        vq.push_back(mk(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'd0, 65));
        vq.push_back(mk(2'b10, 1'b0, 64'd9, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 1));
        vq.push_back(mk(2'b00, 1'b1, 64'd9, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1));
        vq.push_back(mk(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 65));
        vq.push_back(mk(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFE, 65));
        vq.push_back(mk(2'b10, 1'b1, 64'd7, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33));

        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], i);
        end
        held = vq[vq.size()-1].exp;

        // Flush at cycle 10 with an ignored start at cycle 5.
        saw_done = 0;
        control = 2'b01; isword = 1'b0; dividend = 64'd100; divisor = 64'd7;
        dividend_neg = 1'b0; divisor_neg = 1'b0; start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            start = 1'b0;
            if (done) saw_done++;
            if (n == 5) begin start = 1'b1; divisor = 64'd0; end
            if (n == 10) begin
                check("flush_busy_c10", {63'd0, busy}, 64'd1);
                flush = 1'b1;
            end
            if (n == 11) begin
                flush = 1'b0;
                check("flush_ready_c11", {63'd0, ready}, 64'd1);
                check("flush_busy_c11", {63'd0, busy}, 64'd0);
            end
        end
        for (int n = 0; n < 70; n++) begin
            tick();
            if (done) saw_done++;
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_result_held", result, held);

        // Flush together with start in IDLE: start is ignored.
        divisor = 64'd7; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("idle_flush_start_ready", {63'd0, ready}, 64'd1);
        check("idle_flush_start_busy", {63'd0, busy}, 64'd0);

        // Reset at cycle 20 of a new op.
        saw_done = 0;
        start = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            start = 1'b0;
            if (done) saw_done++;
            if (n == 20) rst = 1'b1;
            if (n == 21) begin
                rst = 1'b0;
                check("rst_mid_ready", {63'd0, ready}, 64'd1);
                check("rst_mid_result", result, 64'd0);
                check("rst_mid_busy", {63'd0, busy}, 64'd0);
            end
        end
        for (int n = 0; n < 70; n++) begin
            tick();
            if (done) saw_done++;
        end
        check("rst_mid_no_done", 64'(saw_done), 64'd0);

        // Divider still works after the abort.
        run_vec(vq[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
